aes_subshift: RTL
=================

# aes_subshift

Iterative SubBytes + ShiftRows stage of the AES encryption round datapath. It accepts a 128-bit state after AddRoundKey and substitutes NCOL_PER_CYCLE columns per clock through a shared S-box bank. Each substituted byte is written directly into its ShiftRows position. The result is presented on a valid/ready output that feeds the column-wise MixColumns stage (aes_mixw, one 32-bit column per instance).

## Interface
- NCOL_PER_CYCLE, default 1: columns substituted per cycle. Legal values are 1, 2 and 4. Substitution takes NSUB = 4/NCOL_PER_CYCLE cycles.
- clk  in  1  single clock; all state updates on rising edge.
- nreset  in  1  asynchronous, active-low reset.
- data_v_i  in  1  input state valid.
- data_i  in  128  input state. Byte k = data_i[8k+7:8k] (FIPS-197 byte order). Column c = data_i[32c+31:32c]. Row r of column c = byte 4c+r.
- data_rdy_o  out  1  stage can accept a state this cycle.
- res_v_o  out  1  result valid.
- res_o  out  128  ShiftRows(SubBytes(data_i)), same packing.
- res_rdy_i  in  1  downstream accepts result.

## Operation
- FSM states:
  - IDLE: no data.
  - SUB: substituting; column counter col_q.
  - DONE: result held.
- IDLE → SUB on input handshake (data_v_i & data_rdy_o). The input register captures data_i and col_q is set to 0.
- SUB: each cycle, columns col_q .. col_q+NCOL_PER_CYCLE-1 pass through 4·NCOL_PER_CYCLE S-boxes.
  - Input byte (row r, column c) is written to result byte (row r, column (c−r) mod 4).
  - col_q increments by NCOL_PER_CYCLE, wrapping mod 4.
  - The FSM goes SUB → DONE on the cycle the last column group is written.
- DONE → IDLE on output handshake (res_v_o & res_rdy_i) with no simultaneous input handshake.
- DONE → SUB when output and input handshakes occur in the same cycle.
- data_rdy_o = (state==IDLE) | (state==DONE & res_rdy_i). This is a combinational path from res_rdy_i.
- res_v_o = (state==DONE), driven from a register.
- res_o is stable while res_v_o=1 and res_rdy_i=0. Changes on data_i during SUB are ignored.
- data_v_i while not ready: no capture. The upstream block must hold the data.
- Reset, including mid-SUB or DONE, asynchronously forces:
  - state IDLE, col_q 0, res_o 0, input register 0.
  - res_v_o 0 and data_rdy_o 1 while nreset is low. Any in-flight state is discarded.

## Timing
- Latency: input handshake at edge E0 → res_v_o high after edge E(NSUB), i.e. 4 cycles for NCOL_PER_CYCLE=1 and 1 cycle for 4.
- Throughput with res_rdy_i held high: one state every NSUB+1 cycles. The output handshake and the next input handshake share a cycle.
- No combinational path from data_i or data_v_i to any output.

## Structure
- Shared package aes_pkg holds:
  - the 256-entry S-box constant,
  - a typedef for a 4×4 byte state array,
  - localparams for column and row counts.
- One sub-module, aes_sbox: combinational 8-bit lookup, input op_i, output sbox_o. It is instantiated 4·NCOL_PER_CYCLE times.
- ShiftRows is pure index wiring inside aes_subshift; it has no module of its own.

## Test plan
- FIPS-197 App. B, round 1:
  - stimulus: data_i = 128'h0848f8e9_2a8dc69a_2be2f4a0_bee33d19,
  - response: res_o = 128'he598271e_f11141b8_ae52b4e0_305dbfd4, with res_v_o rising exactly 4 cycles after accept (NCOL_PER_CYCLE=1). Repeat with 2 and 4 and check latencies 2 and 1.
- All-zero input → res_o = 128'h63636363_63636363_63636363_63636363. Byte 0x53 in every position → all bytes 0xed.
- Backpressure: hold res_rdy_i=0 for 10 cycles after DONE.
  - res_o and res_v_o stay stable; data_rdy_o=0 throughout.
  - A pending data_v_i is not captured until the cycle res_rdy_i=1.
- Back-to-back: data_v_i and res_rdy_i held high with three distinct vectors.
  - One result every 5 cycles; each output handshake coincides with the next input handshake.
  - Results match the reference model in order.
- Reset mid-SUB: assert nreset low after the 2nd substitution cycle.
  - res_v_o=0, res_o=0 and data_rdy_o=1 immediately, with no clock edge needed.
  - After release, a new vector produces only its own correct result.
- Input churn: change data_i every cycle during SUB → result equals the transform of the value captured at accept.

Source files
------------

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES round datapath: the forward S-box table,
// the 4x4 byte state type, state dimensions and the SubBytes/ShiftRows FSM
// state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int NCOL = 4;
    localparam int NROW = 4;

    // Packed as [column][row][bit]: s[c][r] occupies bits 32c+8r +: 8, which
    // matches the FIPS-197 byte order of the flat 128-bit bus.
    typedef logic [NCOL-1:0][NROW-1:0][7:0] state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_DONE = 2'd2
    } sub_state_e;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational forward AES S-box lookup.
// Ports:
//   op_i    in  8  byte to substitute
//   sbox_o  out 8  substituted byte
// ---------------------------------------------------------------------------
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] op_i,
    output logic [7:0] sbox_o
);

    assign sbox_o = SBOX[op_i];

endmodule

// File: rtl/aes_subshift.sv
// ---------------------------------------------------------------------------
// aes_subshift
// Iterative SubBytes + ShiftRows. A captured 128-bit state is substituted
// NCOL_PER_CYCLE columns per clock through a shared S-box bank; each byte is
// written straight into its ShiftRows position of the result register.
// Ports:
//   clk         in  1    clock
//   nreset      in  1    asynchronous active-low reset
//   data_v_i    in  1    input state valid
//   data_i      in  128  input state (byte k = data_i[8k+7:8k])
//   data_rdy_o  out 1    stage can accept a state this cycle
//   res_v_o     out 1    result valid (registered)
//   res_o       out 128  ShiftRows(SubBytes(data_i))
//   res_rdy_i   in  1    downstream accepts result
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no data held, ready for a new state
// SUB     | substituting column group col_q .. col_q+NCOL_PER_CYCLE-1
// DONE    | result held on res_o, res_v_o high until handshake
// ---------------------------------------------------------------------------
module aes_subshift
    import aes_pkg::*;
#(
    parameter int NCOL_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         data_v_i,
    input  logic [127:0] data_i,
    output logic         data_rdy_o,
    output logic         res_v_o,
    output logic [127:0] res_o,
    input  logic         res_rdy_i
);

    sub_state_e state_q;
    state_t     in_q;
    state_t     res_q;
    logic [1:0] col_q;
    logic       res_v_q;

    logic       in_hs;
    logic       out_hs;
    logic       last_grp;

    logic [1:0] grp_col  [NCOL_PER_CYCLE];
    logic [7:0] sub_byte [NCOL_PER_CYCLE][NROW];

    // S-box bank: group g works on column col_q+g (mod 4), all four rows.
    for (genvar g = 0; g < NCOL_PER_CYCLE; g++) begin : g_grp
        assign grp_col[g] = col_q + 2'(g);
        for (genvar r = 0; r < NROW; r++) begin : g_row
            aes_sbox u_sbox (
                .op_i   (in_q[grp_col[g]][r]),
                .sbox_o (sub_byte[g][r])
            );
        end
    end

    assign data_rdy_o = (state_q == ST_IDLE) | ((state_q == ST_DONE) & res_rdy_i);
    assign in_hs      = data_v_i & data_rdy_o;
    assign out_hs     = res_v_q & res_rdy_i;
    assign last_grp   = (col_q == 2'(NCOL - NCOL_PER_CYCLE));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            in_q    <= '0;
            res_q   <= '0;
            col_q   <= 2'd0;
            res_v_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_hs) begin
                        in_q    <= data_i;
                        col_q   <= 2'd0;
                        state_q <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    // Row r of column c lands in column (c - r) mod 4; the
                    // 2-bit cast gives the modulo for free.
                    for (int g = 0; g < NCOL_PER_CYCLE; g++) begin
                        for (int r = 0; r < NROW; r++) begin
                            res_q[2'(grp_col[g] - 2'(r))][r] <= sub_byte[g][r];
                        end
                    end
                    col_q <= col_q + 2'(NCOL_PER_CYCLE);
                    if (last_grp) begin
                        state_q <= ST_DONE;
                        res_v_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // An input handshake here implies res_rdy_i, so the
                    // output handshake happens in the same cycle.
                    if (out_hs) begin
                        res_v_q <= 1'b0;
                        if (in_hs) begin
                            in_q    <= data_i;
                            col_q   <= 2'd0;
                            state_q <= ST_SUB;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    res_v_q <= 1'b0;
                end
            endcase
        end
    end

    assign res_v_o = res_v_q;
    assign res_o   = res_q;

endmodule
